// File: rtl/pc_gen.sv
// Fetch-stage program counter: boot/run/halt control, next-PC selection with
// trap and misaligned-target handling, and holding of redirects that arrive during stalls.
module pc_gen #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0,
    parameter logic [ADDRESS_WIDTH-1:0]   TRAP_VECTOR   = ADDRESS_WIDTH'(32'h0000_0100),
    parameter int                         INSTR_BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic [1:0]               pcsrc,
    input  logic [ADDRESS_WIDTH-1:0] pce,
    input  logic [DATA_WIDTH-1:0]    immexte,
    input  logic [DATA_WIDTH-1:0]    aluresult,
    input  logic                     trap,
    input  logic                     halt,
    output logic [ADDRESS_WIDTH-1:0] pcf,
    output logic [ADDRESS_WIDTH-1:0] pcplusf,
    output logic                     fetch_valid,
    output logic                     misaligned,
    output logic                     pending
);

    localparam int ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] held_q, held_d;
    logic                     pending_q, pending_d;
    logic                     mis_q, mis_d;

    logic signed [DATA_WIDTH-1:0] imm_s;
    logic [ADDRESS_WIDTH-1:0]     br_target;
    logic [ADDRESS_WIDTH-1:0]     jalr_target;
    logic [ADDRESS_WIDTH-1:0]     target;
    logic                         redir_req;
    logic                         target_mis;

    // Target selection; pcsrc 11 is never a request, so it has no side effects.
    always_comb begin
        imm_s       = signed'(immexte);
        br_target   = pce + ADDRESS_WIDTH'(imm_s);
        jalr_target = ADDRESS_WIDTH'(aluresult) & ~ADDRESS_WIDTH'(1);
        redir_req   = (pcsrc == 2'b01) || (pcsrc == 2'b10);
        target      = (pcsrc == 2'b10) ? jalr_target : br_target;
        target_mis  = |target[ALIGN_BITS-1:0];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        held_d    = held_q;
        pending_d = pending_q;
        mis_d     = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (trap) begin
                    pc_d      = TRAP_VECTOR;
                    pending_d = 1'b0;
                end else if (redir_req && target_mis) begin
                    pc_d      = TRAP_VECTOR;
                    pending_d = 1'b0;
                    mis_d     = 1'b1;
                end else if (redir_req && !stall) begin
                    pc_d      = target;
                    pending_d = 1'b0;
                end else if (redir_req) begin
                    held_d    = target;
                    pending_d = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pending_q) begin
                    // A released held redirect outranks a halt request.
                    pc_d      = held_q;
                    pending_d = 1'b0;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    pc_d = pcplusf;
                end
            end
            S_HALTED: begin
                if (trap) begin
                    pc_d      = TRAP_VECTOR;
                    pending_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_VECTOR;
            held_q    <= '0;
            pending_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            held_q    <= held_d;
            pending_q <= pending_d;
            mis_q     <= mis_d;
        end
    end

    assign pcf         = pc_q;
    assign pcplusf     = pc_q + STEP;
    assign fetch_valid = (state_q == S_RUN);
    assign misaligned  = mis_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: each scenario task drives stimulus and checks
// outputs 1 ns after the rising edge against hand-computed values.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] pce;
    logic [31:0] immexte;
    logic [31:0] aluresult;
    logic        trap;
    logic        halt;
    logic [31:0] pcf;
    logic [31:0] pcplusf;
    logic        fetch_valid;
    logic        misaligned;
    logic        pending;

    int checks;
    int failures;

    pc_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .pcsrc      (pcsrc),
        .pce        (pce),
        .immexte    (immexte),
        .aluresult  (aluresult),
        .trap       (trap),
        .halt       (halt),
        .pcf        (pcf),
        .pcplusf    (pcplusf),
        .fetch_valid(fetch_valid),
        .misaligned (misaligned),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; pcsrc = 2'b00; pce = '0; immexte = '0;
        aluresult = '0; trap = 1'b0; halt = 1'b0;
        tick(); tick();
        checks++; if (pcf !== 32'h0) begin failures++; $display("FAIL rst_pcf got=%h exp=%h", pcf, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fv got=%b exp=0", fetch_valid); end
        checks++; if (misaligned !== 1'b0 || pending !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", misaligned, pending); end
        rst_n = 1'b1;
        #1;
        checks++; if (pcf !== 32'h0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL boot got pcf=%h fv=%b exp pcf=0 fv=0", pcf, fetch_valid); end
        tick();
        checks++; if (pcf !== 32'h0 || fetch_valid !== 1'b1) begin failures++; $display("FAIL run0 got pcf=%h fv=%b exp pcf=0 fv=1", pcf, fetch_valid); end
        tick();
        checks++; if (pcf !== 32'h4) begin failures++; $display("FAIL run1 got=%h exp=%h", pcf, 32'h4); end
        tick();
        checks++; if (pcf !== 32'h8 || pcplusf !== 32'hC) begin failures++; $display("FAIL run2 got pcf=%h plus=%h exp 8/c", pcf, pcplusf); end
    endtask

    task automatic test_branch_jalr();
        tick(); tick();
        checks++; if (pcf !== 32'h10) begin failures++; $display("FAIL seq10 got=%h exp=%h", pcf, 32'h10); end
        pcsrc = 2'b01; pce = 32'h8; immexte = 32'hFFFF_FFFC;
        tick();
        checks++; if (pcf !== 32'h4) begin failures++; $display("FAIL branch got=%h exp=%h", pcf, 32'h4); end
        pcsrc = 2'b10; aluresult = 32'h41;
        tick();
        checks++; if (pcf !== 32'h40 || misaligned !== 1'b0) begin failures++; $display("FAIL jalr got pcf=%h mis=%b exp 40/0", pcf, misaligned); end
        pcsrc = 2'b00;
        tick();
        checks++; if (pcf !== 32'h44) begin failures++; $display("FAIL after_jalr got=%h exp=%h", pcf, 32'h44); end
    endtask

    task automatic test_stalled_redirect();
        stall = 1'b1; pcsrc = 2'b01; pce = 32'h50; immexte = 32'h10;
        tick();
        checks++; if (pcf !== 32'h44 || pending !== 1'b1) begin failures++; $display("FAIL stall_hold got pcf=%h pend=%b exp 44/1", pcf, pending); end
        pce = 32'h70;
        tick();
        checks++; if (pcf !== 32'h44 || pending !== 1'b1) begin failures++; $display("FAIL stall_over got pcf=%h pend=%b exp 44/1", pcf, pending); end
        pcsrc = 2'b00;
        tick(); tick();
        checks++; if (pcf !== 32'h44 || pending !== 1'b1) begin failures++; $display("FAIL stall_keep got pcf=%h pend=%b exp 44/1", pcf, pending); end
        stall = 1'b0;
        tick();
        checks++; if (pcf !== 32'h80 || pending !== 1'b0) begin failures++; $display("FAIL release got pcf=%h pend=%b exp 80/0", pcf, pending); end
        tick();
        checks++; if (pcf !== 32'h84) begin failures++; $display("FAIL post_release got=%h exp=%h", pcf, 32'h84); end
    endtask

    task automatic test_misaligned_trap();
        pcsrc = 2'b01; pce = 32'h20; immexte = 32'h2;
        tick();
        checks++; if (pcf !== 32'h100 || misaligned !== 1'b1) begin failures++; $display("FAIL mis_br got pcf=%h mis=%b exp 100/1", pcf, misaligned); end
        pcsrc = 2'b00;
        tick();
        checks++; if (pcf !== 32'h104 || misaligned !== 1'b0) begin failures++; $display("FAIL mis_pulse got pcf=%h mis=%b exp 104/0", pcf, misaligned); end
        pcsrc = 2'b10; aluresult = 32'h43;
        tick();
        checks++; if (pcf !== 32'h100 || misaligned !== 1'b1) begin failures++; $display("FAIL mis_jalr got pcf=%h mis=%b exp 100/1", pcf, misaligned); end
        pcsrc = 2'b00;
        tick();
        stall = 1'b1; pcsrc = 2'b01; pce = 32'h200; immexte = 32'h0;
        tick();
        checks++; if (pcf !== 32'h104 || pending !== 1'b1) begin failures++; $display("FAIL trap_pre got pcf=%h pend=%b exp 104/1", pcf, pending); end
        pcsrc = 2'b00; trap = 1'b1;
        tick();
        checks++; if (pcf !== 32'h100 || pending !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL trap_stall got pcf=%h pend=%b mis=%b exp 100/0/0", pcf, pending, misaligned); end
        trap = 1'b0;
        tick();
        stall = 1'b0;
        tick();
        checks++; if (pcf !== 32'h104) begin failures++; $display("FAIL trap_discard got=%h exp=%h", pcf, 32'h104); end
        pcsrc = 2'b11; pce = 32'h300; aluresult = 32'h301;
        tick();
        checks++; if (pcf !== 32'h108 || pending !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL pcsrc11 got pcf=%h pend=%b mis=%b exp 108/0/0", pcf, pending, misaligned); end
        pcsrc = 2'b00;
    endtask

    task automatic test_halt();
        pcsrc = 2'b01; pce = 32'h20; immexte = 32'h0;
        tick();
        pcsrc = 2'b00; halt = 1'b1;
        tick();
        checks++; if (pcf !== 32'h20 || fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_enter got pcf=%h fv=%b exp 20/0", pcf, fetch_valid); end
        halt = 1'b0; pcsrc = 2'b01; pce = 32'h0; immexte = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (pcf !== 32'h20 || fetch_valid !== 1'b0 || pending !== 1'b0) begin failures++; $display("FAIL halt_frozen%0d got pcf=%h fv=%b pend=%b exp 20/0/0", i, pcf, fetch_valid, pending); end
        end
        pcsrc = 2'b00; trap = 1'b1;
        tick();
        checks++; if (pcf !== 32'h100 || fetch_valid !== 1'b1) begin failures++; $display("FAIL halt_trap got pcf=%h fv=%b exp 100/1", pcf, fetch_valid); end
        trap = 1'b0;
        tick();
        stall = 1'b1; halt = 1'b1;
        tick();
        checks++; if (pcf !== 32'h104 || fetch_valid !== 1'b1) begin failures++; $display("FAIL halt_stalled got pcf=%h fv=%b exp 104/1", pcf, fetch_valid); end
        stall = 1'b0;
        tick();
        checks++; if (pcf !== 32'h104 || fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_release got pcf=%h fv=%b exp 104/0", pcf, fetch_valid); end
        halt = 1'b0; trap = 1'b1;
        tick();
        trap = 1'b0; halt = 1'b1; pcsrc = 2'b01; pce = 32'h300; immexte = 32'h0;
        tick();
        checks++; if (pcf !== 32'h300 || fetch_valid !== 1'b1) begin failures++; $display("FAIL halt_vs_redir got pcf=%h fv=%b exp 300/1", pcf, fetch_valid); end
        halt = 1'b0; pcsrc = 2'b00;
    endtask

    task automatic test_wrap();
        pcsrc = 2'b10; aluresult = 32'hFFFF_FFFC;
        tick();
        checks++; if (pcf !== 32'hFFFF_FFFC || pcplusf !== 32'h0) begin failures++; $display("FAIL wrap_top got pcf=%h plus=%h exp fffffffc/0", pcf, pcplusf); end
        pcsrc = 2'b00;
        tick();
        checks++; if (pcf !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=%h", pcf, 32'h0); end
        pcsrc = 2'b01; pce = 32'h4; immexte = 32'hFFFF_FFF8;
        tick();
        checks++; if (pcf !== 32'hFFFF_FFFC) begin failures++; $display("FAIL br_wrap got=%h exp=%h", pcf, 32'hFFFF_FFFC); end
        pcsrc = 2'b00;
        tick();
        tick();
        checks++; if (pcf !== 32'h4) begin failures++; $display("FAIL wrap_seq got=%h exp=%h", pcf, 32'h4); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; pcsrc = 2'b01; pce = 32'h10; immexte = 32'h10;
        tick();
        checks++; if (pending !== 1'b1 || pcf !== 32'h4) begin failures++; $display("FAIL ar_pre got pcf=%h pend=%b exp 4/1", pcf, pending); end
        pcsrc = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pcf !== 32'h0 || pending !== 1'b0 || fetch_valid !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL ar_mid got pcf=%h pend=%b fv=%b mis=%b exp 0/0/0/0", pcf, pending, fetch_valid, misaligned); end
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (pcf !== 32'h0 || fetch_valid !== 1'b1) begin failures++; $display("FAIL ar_boot got pcf=%h fv=%b exp 0/1", pcf, fetch_valid); end
        tick();
        checks++; if (pcf !== 32'h4 || pending !== 1'b0) begin failures++; $display("FAIL ar_discard got pcf=%h pend=%b exp 4/0", pcf, pending); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_branch_jalr();
        test_stalled_redirect();
        test_misaligned_trap();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
